// File: rtl/cpu_pkg.sv
// Shared constants for the Mini SRC control sequencer: opcode map, ALU
// function codes, FSM state encoding and small opcode-decode helpers.
package cpu_pkg;

    localparam int OPCODE_W_DEFAULT = 5;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_SHR  = 5'd5;
    localparam logic [4:0] OP_SHL  = 5'd6;
    localparam logic [4:0] OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8;
    localparam logic [4:0] OP_AND  = 5'd9;
    localparam logic [4:0] OP_OR   = 5'd10;
    localparam logic [4:0] OP_ADDI = 5'd11;
    localparam logic [4:0] OP_ANDI = 5'd12;
    localparam logic [4:0] OP_ORI  = 5'd13;
    localparam logic [4:0] OP_NEG  = 5'd16;
    localparam logic [4:0] OP_NOT  = 5'd17;
    localparam logic [4:0] OP_BR   = 5'd18;
    localparam logic [4:0] OP_JR   = 5'd19;
    localparam logic [4:0] OP_NOP  = 5'd25;
    localparam logic [4:0] OP_HALT = 5'd26;

    // ALU function codes reuse the opcode numbering
    localparam logic [4:0] ALU_ADD = OP_ADD;
    localparam logic [4:0] ALU_AND = OP_AND;
    localparam logic [4:0] ALU_OR  = OP_OR;

    localparam logic [3:0] S_RST       = 4'd0;
    localparam logic [3:0] S_T0        = 4'd1;
    localparam logic [3:0] S_T1        = 4'd2;
    localparam logic [3:0] S_T2        = 4'd3;
    localparam logic [3:0] S_T3        = 4'd4;
    localparam logic [3:0] S_T4        = 4'd5;
    localparam logic [3:0] S_T5        = 4'd6;
    localparam logic [3:0] S_T6        = 4'd7;
    localparam logic [3:0] S_T7        = 4'd8;
    localparam logic [3:0] S_HALTED    = 4'd9;
    localparam logic [3:0] S_WAIT_STEP = 4'd10;

    function automatic logic op_legal(input logic [4:0] op);
        case (op)
            OP_LD, OP_LDI, OP_ST,
            OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR,
            OP_ADDI, OP_ANDI, OP_ORI, OP_NEG, OP_NOT, OP_BR, OP_JR,
            OP_NOP, OP_HALT: op_legal = 1'b1;
            default:         op_legal = 1'b0;
        endcase
    endfunction

    // ALU function used by the immediate forms
    function automatic logic [4:0] imm_alu(input logic [4:0] op);
        case (op)
            OP_ANDI: imm_alu = ALU_AND;
            OP_ORI:  imm_alu = ALU_OR;
            default: imm_alu = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait watchdog: down-counter loaded with MEM_TIMEOUT-1 while clear is
// high, decremented on each enabled (waiting) cycle; expired flags terminal
// count, i.e. the MEM_TIMEOUT-th consecutive waiting cycle.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int              CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    assign expired = (cnt == '0);

    // Reload outside wait states, count down while waiting, hold at zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= LOAD;
        end else if (clear) begin
            cnt <= LOAD;
        end else if (en && !expired) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Mini SRC control sequencer: fetch, decode and execute strobe generation.
// Optional single-step mode under macro SEQ_SINGLE_STEP_EN.
//
//  state     | meaning
//  ----------+-----------------------------------------------
//  RST       | held in reset, all outputs 0
//  T0        | PC -> MAR, PC increment into Z
//  T1        | PC update, memory read into MDR (waits ready)
//  T2        | MDR -> IR
//  T3..T7    | execute steps, decoded from ir[31:27]
//  HALTED    | halt / illegal opcode / memory timeout, until reset
//  WAIT_STEP | single-step idle between instructions
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int OPCODE_W    = OPCODE_W_DEFAULT,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [31:0]         ir,
    input  logic                con_ff,
    input  logic                mem_ready,
    output logic                pc_out,
    output logic                pc_in,
    output logic                inc_pc,
    output logic                mar_in,
    output logic                mdr_in,
    output logic                mdr_out,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_in,
    output logic                y_in,
    output logic                z_in,
    output logic                zlow_out,
    output logic                c_out,
    output logic                con_in,
    output logic                gra,
    output logic                grb,
    output logic                grc,
    output logic                r_in,
    output logic                r_out,
    output logic                ba_out,
    output logic [OPCODE_W-1:0] alu_op,
    output logic                run,
    output logic                ill_op,
    output logic                mem_err
`ifdef SEQ_SINGLE_STEP_EN
    ,
    input  logic                step
`endif
);

    logic [3:0]          state, state_nxt;
    logic [OPCODE_W-1:0] op;
    logic                unused_ir_bits;
    logic                is_r, is_imm, is_un, is_addr;
    logic                in_wait, expired;
    logic                set_ill, set_merr;
    logic [3:0]          done_state;

    assign op             = ir[31:32-OPCODE_W];
    assign unused_ir_bits = ^ir[31-OPCODE_W:0];

    assign is_r    = (op >= OP_ADD) && (op <= OP_OR);
    assign is_imm  = (op >= OP_ADDI) && (op <= OP_ORI);
    assign is_un   = (op == OP_NEG) || (op == OP_NOT);
    assign is_addr = (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);

    assign in_wait = (state == S_T1)
                  || ((state == S_T6) && (op == OP_LD))
                  || ((state == S_T7) && (op == OP_ST));

`ifdef SEQ_SINGLE_STEP_EN
    assign done_state = S_WAIT_STEP;
`else
    assign done_state = S_T0;
`endif

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (!in_wait),
        .en      (in_wait && !mem_ready),
        .expired (expired)
    );

    // Next-state decode; a ready on the terminal-count cycle still advances
    always_comb begin
        state_nxt = state;
        set_ill   = 1'b0;
        set_merr  = 1'b0;
        case (state)
            S_RST: state_nxt = S_T0;
            S_T0:  state_nxt = S_T1;
            S_T1: begin
                if (mem_ready) begin
                    state_nxt = S_T2;
                end else if (expired) begin
                    state_nxt = S_HALTED;
                    set_merr  = 1'b1;
                end
            end
            S_T2:  state_nxt = S_T3;
            S_T3: begin
                if (!op_legal(op)) begin
                    state_nxt = S_HALTED;
                    set_ill   = 1'b1;
                end else if (op == OP_HALT) begin
                    state_nxt = S_HALTED;
                end else if ((op == OP_JR) || (op == OP_NOP)) begin
                    state_nxt = done_state;
                end else begin
                    state_nxt = S_T4;
                end
            end
            S_T4:  state_nxt = is_un ? done_state : S_T5;
            S_T5: begin
                if ((op == OP_LD) || (op == OP_ST) || (op == OP_BR)) begin
                    state_nxt = S_T6;
                end else begin
                    state_nxt = done_state;
                end
            end
            S_T6: begin
                if (op == OP_LD) begin
                    if (mem_ready) begin
                        state_nxt = S_T7;
                    end else if (expired) begin
                        state_nxt = S_HALTED;
                        set_merr  = 1'b1;
                    end
                end else if (op == OP_ST) begin
                    state_nxt = S_T7;
                end else begin
                    state_nxt = done_state;
                end
            end
            S_T7: begin
                if (op == OP_ST) begin
                    if (mem_ready) begin
                        state_nxt = done_state;
                    end else if (expired) begin
                        state_nxt = S_HALTED;
                        set_merr  = 1'b1;
                    end
                end else begin
                    state_nxt = done_state;
                end
            end
            S_HALTED: state_nxt = S_HALTED;
`ifdef SEQ_SINGLE_STEP_EN
            S_WAIT_STEP: state_nxt = step ? S_T0 : S_WAIT_STEP;
`else
            S_WAIT_STEP: state_nxt = S_T0;
`endif
            default: state_nxt = S_HALTED;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_RST;
        end else begin
            state <= state_nxt;
        end
    end

    // Sticky fault flags, cleared only by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ill_op  <= 1'b0;
            mem_err <= 1'b0;
        end else begin
            if (set_ill) begin
                ill_op <= 1'b1;
            end
            if (set_merr) begin
                mem_err <= 1'b1;
            end
        end
    end

    // Moore strobe decode from state and opcode
    always_comb begin
        {pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, mem_read, mem_write} = '0;
        {ir_in, y_in, z_in, zlow_out, c_out, con_in}                          = '0;
        {gra, grb, grc, r_in, r_out, ba_out}                                  = '0;
        alu_op = '0;
        run    = (state >= S_T0) && (state <= S_T7);
        case (state)
            S_T0: begin
                pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1;
            end
            S_T1: begin
                zlow_out = 1'b1; pc_in = 1'b1; mem_read = 1'b1; mdr_in = 1'b1;
            end
            S_T2: begin
                mdr_out = 1'b1; ir_in = 1'b1;
            end
            S_T3: begin
                if (is_r || is_imm) begin
                    grb = 1'b1; r_out = 1'b1; y_in = 1'b1;
                end else if (is_un) begin
                    grb = 1'b1; r_out = 1'b1; alu_op = op; z_in = 1'b1;
                end else if (is_addr) begin
                    grb = 1'b1; ba_out = 1'b1; y_in = 1'b1;
                end else if (op == OP_BR) begin
                    gra = 1'b1; r_out = 1'b1; con_in = 1'b1;
                end else if (op == OP_JR) begin
                    gra = 1'b1; r_out = 1'b1; pc_in = 1'b1;
                end
            end
            S_T4: begin
                if (is_r) begin
                    grc = 1'b1; r_out = 1'b1; alu_op = op; z_in = 1'b1;
                end else if (is_un) begin
                    zlow_out = 1'b1; gra = 1'b1; r_in = 1'b1;
                end else if (is_imm) begin
                    c_out = 1'b1; alu_op = imm_alu(op); z_in = 1'b1;
                end else if (is_addr) begin
                    c_out = 1'b1; alu_op = ALU_ADD; z_in = 1'b1;
                end else if (op == OP_BR) begin
                    pc_out = 1'b1; y_in = 1'b1;
                end
            end
            S_T5: begin
                if (is_r || is_imm || (op == OP_LDI)) begin
                    zlow_out = 1'b1; gra = 1'b1; r_in = 1'b1;
                end else if ((op == OP_LD) || (op == OP_ST)) begin
                    zlow_out = 1'b1; mar_in = 1'b1;
                end else if (op == OP_BR) begin
                    c_out = 1'b1; alu_op = ALU_ADD; z_in = 1'b1;
                end
            end
            S_T6: begin
                if (op == OP_LD) begin
                    mem_read = 1'b1; mdr_in = 1'b1;
                end else if (op == OP_ST) begin
                    gra = 1'b1; r_out = 1'b1; mdr_in = 1'b1;
                end else if ((op == OP_BR) && con_ff) begin
                    zlow_out = 1'b1; pc_in = 1'b1;
                end
            end
            S_T7: begin
                if (op == OP_LD) begin
                    mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1;
                end else if (op == OP_ST) begin
                    mem_write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer. The reference model expands each
// instruction into its list of expected per-cycle output words (strobe table
// per opcode class, memory steps stretched by a chosen ready delay) and the
// driver compares the DUT output word against it on every falling edge.
module tb_control_sequencer;

    localparam int MEM_TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] ir = '0;
    logic        con_ff = 1'b0;
    logic        mem_ready = 1'b0;
    logic        step = 1'b0;
    logic        pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, mem_read, mem_write;
    logic        ir_in, y_in, z_in, zlow_out, c_out, con_in;
    logic        gra, grb, grc, r_in, r_out, ba_out;
    logic [4:0]  alu_op;
    logic        run, ill_op, mem_err;

    always #5 clk = ~clk;

    control_sequencer #(.OPCODE_W(5), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .ir(ir), .con_ff(con_ff), .mem_ready(mem_ready),
        .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc), .mar_in(mar_in),
        .mdr_in(mdr_in), .mdr_out(mdr_out), .mem_read(mem_read), .mem_write(mem_write),
        .ir_in(ir_in), .y_in(y_in), .z_in(z_in), .zlow_out(zlow_out), .c_out(c_out),
        .con_in(con_in), .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out),
        .ba_out(ba_out), .alu_op(alu_op), .run(run), .ill_op(ill_op), .mem_err(mem_err)
`ifdef SEQ_SINGLE_STEP_EN
        , .step(step)
`endif
    );

    // Output word: {20 strobes, alu_op, run, ill_op, mem_err}
    logic [27:0] obs;
    assign obs = {pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, mem_read, mem_write,
                  ir_in, y_in, z_in, zlow_out, c_out, con_in,
                  gra, grb, grc, r_in, r_out, ba_out, alu_op, run, ill_op, mem_err};

    localparam logic [19:0] PC_OUT = 20'h80000, PC_IN = 20'h40000, INC_PC = 20'h20000,
                            MAR_IN = 20'h10000, MDR_IN = 20'h08000, MDR_OUT = 20'h04000,
                            MEM_RD = 20'h02000, MEM_WR = 20'h01000, IR_IN = 20'h00800,
                            Y_IN = 20'h00400, Z_IN = 20'h00200, ZLOW = 20'h00100,
                            C_OUT = 20'h00080, CON_IN = 20'h00040, GRA = 20'h00020,
                            GRB = 20'h00010, GRC = 20'h00008, R_IN = 20'h00004,
                            R_OUT = 20'h00002, BA_OUT = 20'h00001;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [27:0] exp_q[$];
    bit          rdy_q[$];
    bit          stp_q[$];
    bit          m_ill = 1'b0;
    bit          m_merr = 1'b0;
    int          fetch_d = 0;
    int          exec_d = 0;

    task automatic chk(input string tag, input logic [27:0] got, input logic [27:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    // Ready delay: forced value, else mostly short, sometimes limit or timeout
    function automatic int pick_d(input int forced);
        int r;
        if (forced >= 0) return forced;
        r = $urandom_range(0, 19);
        if (r == 0) return MEM_TIMEOUT;
        if (r == 1) return MEM_TIMEOUT - 1;
        return $urandom_range(0, 3);
    endfunction

    task automatic push(input logic [19:0] s, input logic [4:0] alu);
        exp_q.push_back({s, alu, 1'b1, m_ill, m_merr});
        rdy_q.push_back(1'($urandom_range(0, 1)));
        stp_q.push_back(1'b0);
    endtask

    task automatic push_idle(input bit stp);
        exp_q.push_back({20'h0, 5'h0, 1'b0, m_ill, m_merr});
        rdy_q.push_back(1'($urandom_range(0, 1)));
        stp_q.push_back(stp);
    endtask

    // Memory step: d not-ready cycles then a ready cycle; d >= limit times out
    task automatic push_mem(input logic [19:0] s, input int d, output bit to);
        to = (d >= MEM_TIMEOUT);
        for (int i = 0; i < (to ? MEM_TIMEOUT : d + 1); i++) begin
            push(s, 5'h0);
            rdy_q[rdy_q.size() - 1] = (!to && i == d);
        end
    endtask

    task automatic build(input logic [4:0] op, input bit con, output bit halted);
        bit to;
        halted = 1'b0;
        push(PC_OUT | MAR_IN | INC_PC | Z_IN, 5'd0);
        push_mem(ZLOW | PC_IN | MEM_RD | MDR_IN, pick_d(fetch_d), to);
        if (to) begin
            m_merr = 1'b1;
            halted = 1'b1;
        end else begin
            push(MDR_OUT | IR_IN, 5'd0);
            case (op) inside
                5'd0, 5'd1, 5'd2: begin
                    push(GRB | BA_OUT | Y_IN, 5'd0);
                    push(C_OUT | Z_IN, 5'd3);
                    if (op == 5'd1) begin
                        push(ZLOW | GRA | R_IN, 5'd0);
                    end else begin
                        push(ZLOW | MAR_IN, 5'd0);
                        if (op == 5'd0) begin
                            push_mem(MEM_RD | MDR_IN, pick_d(exec_d), to);
                            if (!to) push(MDR_OUT | GRA | R_IN, 5'd0);
                        end else begin
                            push(GRA | R_OUT | MDR_IN, 5'd0);
                            push_mem(MEM_WR, pick_d(exec_d), to);
                        end
                        if (to) begin
                            m_merr = 1'b1;
                            halted = 1'b1;
                        end
                    end
                end
                [5'd3:5'd10]: begin
                    push(GRB | R_OUT | Y_IN, 5'd0);
                    push(GRC | R_OUT | Z_IN, op);
                    push(ZLOW | GRA | R_IN, 5'd0);
                end
                5'd11, 5'd12, 5'd13: begin
                    push(GRB | R_OUT | Y_IN, 5'd0);
                    push(C_OUT | Z_IN, (op == 5'd11) ? 5'd3 : (op == 5'd12) ? 5'd9 : 5'd10);
                    push(ZLOW | GRA | R_IN, 5'd0);
                end
                5'd16, 5'd17: begin
                    push(GRB | R_OUT | Z_IN, op);
                    push(ZLOW | GRA | R_IN, 5'd0);
                end
                5'd18: begin
                    push(GRA | R_OUT | CON_IN, 5'd0);
                    push(PC_OUT | Y_IN, 5'd0);
                    push(C_OUT | Z_IN, 5'd3);
                    push(con ? (ZLOW | PC_IN) : 20'h0, 5'd0);
                end
                5'd19: push(GRA | R_OUT | PC_IN, 5'd0);
                5'd25: push(20'h0, 5'd0);
                5'd26: begin
                    push(20'h0, 5'd0);
                    halted = 1'b1;
                end
                default: begin
                    push(20'h0, 5'd0);
                    m_ill  = 1'b1;
                    halted = 1'b1;
                end
            endcase
        end
        if (halted) begin
            for (int i = 0; i < 3; i++) push_idle(1'b0);
        end else begin
`ifdef SEQ_SINGLE_STEP_EN
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) push_idle(1'b0);
            push_idle(1'b1);
`endif
        end
    endtask

    // Play n queued cycles (n < 0: all)
    task automatic play(input string tag, input logic [31:0] ir_v, input bit con, input int n);
        int k = 0;
        while (exp_q.size() > 0 && (n < 0 || k < n)) begin
            @(negedge clk);
            ir = ir_v;
            con_ff = con;
            chk(tag, obs, exp_q.pop_front());
            mem_ready = rdy_q.pop_front();
            step = stp_q.pop_front();
            k++;
        end
    endtask

    task automatic run_instr(input string tag, input logic [31:0] ir_v, input bit con, output bit halted);
        build(ir_v[31:27], con, halted);
        play(tag, ir_v, con, -1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        step = 1'b0;
        #1 chk("reset_now", obs, 28'h0);
        @(negedge clk);
        chk("reset_hold", obs, 28'h0);
        m_ill = 1'b0;
        m_merr = 1'b0;
        reset_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          h;
        logic [4:0]  op;
        logic [31:0] ir_v;

        #1 chk("reset_init", obs, 28'h0);
        do_reset();

        fetch_d = 0; exec_d = 0;
        run_instr("add", 32'h18918000, 1'b0, h);
        exec_d = 3;
        run_instr("ld_wait3", {5'd0, 4'd1, 4'd2, 19'h10}, 1'b0, h);
        exec_d = MEM_TIMEOUT - 1;
        run_instr("ld_limit", {5'd0, 4'd1, 4'd2, 19'h10}, 1'b0, h);
        exec_d = 0;
        run_instr("br_nt", {5'd18, 27'h0800010}, 1'b0, h);
        run_instr("br_t", {5'd18, 27'h0800010}, 1'b1, h);
        run_instr("nop", {5'd25, 27'h0}, 1'b0, h);
        run_instr("nop2", {5'd25, 27'h0}, 1'b0, h);

        fetch_d = MEM_TIMEOUT;
        run_instr("fetch_timeout", {5'd3, 27'h0}, 1'b0, h);
        do_reset();
        fetch_d = 0;

        run_instr("mul_illegal", {5'd14, 27'h0}, 1'b0, h);
        do_reset();

        // st aborted by reset while its write is pending
        exec_d = 5;
        build(5'd2, 1'b0, h);
        play("st_abort", {5'd2, 27'h0}, 1'b0, 9);
        #2 chk("st_t7_write", 28'(mem_write), 28'd1);
        reset_n = 1'b0;
        #1 chk("st_abort_now", obs, 28'h0);
        exp_q.delete(); rdy_q.delete(); stp_q.delete();
        @(negedge clk);
        m_ill = 1'b0;
        m_merr = 1'b0;
        reset_n = 1'b1;
        run_instr("after_abort", {5'd12, 27'h0}, 1'b0, h);

        fetch_d = -1; exec_d = -1;
        for (int i = 0; i < 150; i++) begin
            op = 5'($urandom_range(0, 31));
            if ((op == 5'd14 || op == 5'd15 || (op >= 5'd20 && op != 5'd25)) && $urandom_range(0, 3) != 0)
                op = 5'($urandom_range(3, 10));
            ir_v = {op, 27'($urandom)};
            run_instr($sformatf("rand_op%0d", op), ir_v, 1'($urandom_range(0, 1)), h);
            if (h) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
